// File: rtl/wall_map_server.sv
// wall_map_server: tank-game wall bitmap with a free-running display read port, a query port
// for game logic and, when WALL_MAP_BREAKABLE_EN is defined, destructible interior walls.
module wall_map_server #(
  parameter int MAP_W = 64,
  parameter int MAP_H = 44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [5:0] i_request_x,
  input  logic [5:0] i_request_y,
  output logic       o_is_wall,
  input  logic       i_q_valid,
  input  logic [5:0] i_q_x,
  input  logic [5:0] i_q_y,
  output logic       o_q_ready,
  output logic       o_q_valid,
  output logic       o_q_is_wall,
  input  logic       i_break_valid,
  input  logic [5:0] i_break_x,
  input  logic [5:0] i_break_y,
  output logic       o_break_hit,
  output logic       o_map_ready,
  output logic       dbg_state
);

  localparam int ROW_W = $clog2(MAP_H);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [MAP_W-1:0]   map_q [MAP_H];
  logic               q_accept;
  logic               break_fire;

  // Border ring plus a 2x2 block in every 8x8 tile where both coordinates have bits [2:1] == 2'b10.
  function automatic logic [MAP_W-1:0] init_row(input logic [ROW_W-1:0] y);
    logic [MAP_W-1:0] r;
    logic             inner_y;
    inner_y = (y[2:1] == 2'b10);
    r = '0;
    for (int x = 0; x < MAP_W; x++) begin
      r[x] = (x == 0) || (x == MAP_W - 1) || (inner_y && (x[2:1] == 2'b10));
    end
    if ((y == '0) || (y == ROW_W'(MAP_H - 1))) r = '1;
    return r;
  endfunction

  // Anything outside the field reads as wall so movers can never leave it.
  function automatic logic rd_cell(input logic [5:0] x, input logic [5:0] y);
    if ((int'(y) >= MAP_H) || (int'(x) >= MAP_W)) return 1'b1;
    return map_q[y][x];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (i_load) begin
      state_d = INIT;
      row_d   = '0;
    end else if (state_q == INIT) begin
      if (row_q == ROW_W'(MAP_H - 1)) begin
        state_d = READY;
        row_d   = '0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  assign o_map_ready = (state_q == READY);
  assign o_q_ready   = (state_q == READY);
  assign dbg_state   = state_q;

  // Query handshake: a query transfers on a cycle with i_q_valid && o_q_ready; o_q_valid pulses
  // on the following cycle with o_q_is_wall, which otherwise holds its last response.
  assign q_accept = i_q_valid && o_q_ready;

`ifdef WALL_MAP_BREAKABLE_EN
  logic break_interior;
  assign break_interior = (int'(i_break_x) >= 1) && (int'(i_break_x) <= MAP_W - 2) &&
                          (int'(i_break_y) >= 1) && (int'(i_break_y) <= MAP_H - 2);
  // A coinciding i_load wins; reads this cycle still see the pre-break bit.
  assign break_fire = i_break_valid && !i_load && (state_q == READY) && break_interior &&
                      rd_cell(i_break_x, i_break_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_break_hit <= 1'b0;
    else        o_break_hit <= break_fire;
  end
`else
  logic unused_break;
  assign unused_break = ^{i_break_valid, i_break_x, i_break_y};
  assign break_fire   = 1'b0;
  assign o_break_hit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAP_H; r++) map_q[r] <= '0;
    end else if (state_q == INIT) begin
      if (!i_load) map_q[row_q] <= init_row(row_q);
`ifdef WALL_MAP_BREAKABLE_EN
    end else if (break_fire) begin
      map_q[i_break_y][i_break_x] <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_is_wall   <= 1'b0;
      o_q_valid   <= 1'b0;
      o_q_is_wall <= 1'b0;
    end else begin
      o_is_wall <= rd_cell(i_request_x, i_request_y);
      o_q_valid <= q_accept;
      if (q_accept) o_q_is_wall <= rd_cell(i_q_x, i_q_y);
    end
  end

endmodule

// File: doc/wall_map_server.md
WALL_MAP_SERVER -- requirements
Module: wall_map_server

Interface
REQ-001 Parameter MAP_W, default 64, SHALL set the game-field width in grids.
REQ-002 Parameter MAP_H, default 44, SHALL set the game-field height in grids, i.e. display height minus status-bar rows.
REQ-003 clk  input  1  SHALL be the single system clock, shared with the VGA block.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_load  input  1  SHALL be a one-cycle pulse that regenerates the map, issued on game start.
REQ-006 i_request_x, i_request_y  input  6 each  SHALL be the display-side grid coordinate from the VGA block.
REQ-007 o_is_wall  output  1  SHALL be the wall bit for the display-side coordinate.
REQ-008 i_q_valid, i_q_x[5:0], i_q_y[5:0]  input  SHALL form the game-logic query request for tank/shell collision checks.
REQ-009 o_q_ready  output  1  SHALL indicate that a game query is accepted this cycle.
REQ-010 o_q_valid, o_q_is_wall  output  1 each  SHALL carry the game query response.
REQ-011 i_break_valid, i_break_x[5:0], i_break_y[5:0]  input  SHALL request that a wall cell be destroyed.
REQ-012 o_break_hit  output  1  SHALL pulse when a break request actually cleared a wall.
REQ-013 o_map_ready  output  1  SHALL be high when the map is fully generated.

Function
REQ-014 Storage SHALL be MAP_H row registers of MAP_W bits; bit (x,y) = 1 means wall.
REQ-015 FSM states SHALL be INIT and READY; INIT SHALL write one full row per cycle, row counter 0..MAP_H-1, then go to READY.
REQ-016 The init pattern SHALL set cell (x,y) to wall iff y==0, or y==MAP_H-1, or x==0, or x==MAP_W-1, or (x[2:1]==2'b10 and y[2:1]==2'b10).
REQ-017 i_load in any state SHALL restart INIT at row 0 on the next edge; the remaining rows are overwritten by the new pass.
REQ-018 o_map_ready SHALL be 1 only in READY and SHALL drop the cycle after i_load is sampled.
REQ-019 Display port: o_is_wall SHALL be registered with latency 1 from i_request_x/y, SHALL be evaluated every cycle in every state, and SHALL never stall.
REQ-020 Any coordinate with y>=MAP_H or x>=MAP_W SHALL read as wall (1) on both read ports.
REQ-021 o_q_ready SHALL equal (state==READY).
REQ-022 A query is accepted on i_q_valid & o_q_ready; o_q_valid SHALL pulse exactly one cycle later, with o_q_is_wall registered alongside it.
REQ-023 o_q_is_wall SHALL hold its last value while o_q_valid is 0; back-to-back queries SHALL give one response per cycle.
REQ-024 Display and query reads SHALL be independent muxes with no arbitration between them.
REQ-025 A break SHALL take effect only in READY, for an interior cell (not border, in range) that is currently wall: clear the bit on the next edge and pulse o_break_hit for one cycle.
REQ-026 All other break requests SHALL be ignored, with o_break_hit kept at 0.
REQ-027 A same-cycle read and break of the same cell SHALL return the pre-break value (read-before-write).
REQ-028 If i_load and i_break_valid coincide, i_load SHALL win and the break SHALL be dropped.

Reset
REQ-029 Asserting rst_n low SHALL clear all map bits, o_is_wall, o_q_valid, o_q_is_wall, o_break_hit and o_map_ready to 0.
REQ-030 Reset SHALL set the state to INIT with row counter 0, so generation starts automatically after deassertion.
REQ-031 Reset mid-INIT or mid-query SHALL abandon the operation with no response pulse.

Configuration
REQ-032 Macro WALL_MAP_BREAKABLE_EN defined: REQ-025..REQ-028 SHALL apply as written.
REQ-033 Macro WALL_MAP_BREAKABLE_EN undefined: break inputs SHALL be ignored, o_break_hit SHALL be tied to 0, and the map SHALL change only through INIT.

Verification
REQ-034 Release reset, idle 44 cycles -> o_map_ready=1 at cycle 45; queries (0,0)=1, (4,4)=1, (6,4)=0, (12,13)=1, (10,10)=0, (20,43)=1.
REQ-035 Display port sweep of all 64x44 cells -> o_is_wall matches REQ-016 with 1-cycle latency; y=44..63 returns 1.
REQ-036 During INIT, i_q_valid=1 -> o_q_ready=0 and no o_q_valid; first accept after READY -> response the next cycle.
REQ-037 Break (4,4) in READY -> o_break_hit=1 for one cycle, then query (4,4)=0; break (0,5) -> hit=0 and cell stays 1; break (4,4) again -> hit=0.
REQ-038 Same cycle: query (12,12) and break (12,12) -> response 1, then a later query returns 0.
REQ-039 Break (4,4), then i_load -> o_map_ready=0 for 44 cycles, then (4,4)=1; with the macro undefined, break (4,4) -> hit=0 and cell stays 1.
